// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the IF/MEM memory bus arbiter.
package mem_bus_arbiter_pkg;

   localparam int unsigned DEF_ADDR_W      = 64;
   localparam int unsigned DEF_DATA_W      = 64;
   localparam int unsigned DEF_TIMEOUT_CYC = 256;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWNER_IF  = 1'b0,
      OWNER_MEM = 1'b1
   } arb_owner_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Pipeline-side (IF, MEM) and memory-side handshake signals of the arbiter.
interface mem_bus_arbiter_if #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64
);
   localparam int unsigned STRB_W = DATA_W / 8;

   logic              if_valid;
   logic [ADDR_W-1:0] if_addr;
   logic              if_flush;
   logic              if_ready;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic              mem_valid;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [STRB_W-1:0] mem_wstrb;
   logic              mem_ready;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;

   logic              bus_req_valid;
   logic              bus_req_ready;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic [STRB_W-1:0] bus_wstrb;
   logic              bus_resp_valid;
   logic [DATA_W-1:0] bus_resp_data;
   logic              bus_timeout;

   // Arbiter side
   modport slave (
      input  if_valid, if_addr, if_flush,
      output if_ready, if_rvalid, if_rdata,
      input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rvalid, mem_rdata,
      output bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb, bus_timeout,
      input  bus_req_ready, bus_resp_valid, bus_resp_data
   );

   // Pipeline and memory bridge side
   modport master (
      output if_valid, if_addr, if_flush,
      input  if_ready, if_rvalid, if_rdata,
      output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rvalid, mem_rdata,
      input  bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wstrb, bus_timeout,
      output bus_req_ready, bus_resp_valid, bus_resp_data
   );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding memory bus arbiter: MEM over IF, latched request,
// registered response pulse, IF flush drop and response timeout abort.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input logic                clk,
   input logic                rst,
   mem_bus_arbiter_if.slave   bus_if
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYC);

   arb_state_e        r_state;
   arb_owner_e        r_owner;
   logic              r_drop;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [STRB_W-1:0] r_wstrb;
   logic              r_if_rvalid;
   logic [DATA_W-1:0] r_if_rdata;
   logic              r_mem_rvalid;
   logic [DATA_W-1:0] r_mem_rdata;
   logic              r_timeout;

   logic w_idle;
   logic w_mem_hs;
   logic w_if_hs;
   logic w_drop;
   logic w_abort;

   // Ready is only offered from IDLE; held low while reset is asserted
   assign w_idle   = (r_state == ST_IDLE) & ~rst;
   assign w_mem_hs = w_idle & bus_if.mem_valid;
   assign w_if_hs  = w_idle & bus_if.if_valid & ~bus_if.mem_valid & ~bus_if.if_flush;
   assign w_drop   = r_drop | ((r_owner == OWNER_IF) & bus_if.if_flush);
   assign w_abort  = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

   assign bus_if.mem_ready     = w_mem_hs;
   assign bus_if.if_ready      = w_if_hs;
   assign bus_if.bus_req_valid = (r_state == ST_REQ);
   assign bus_if.bus_we        = r_we;
   assign bus_if.bus_addr      = r_addr;
   assign bus_if.bus_wdata     = r_wdata;
   assign bus_if.bus_wstrb     = r_wstrb;
   assign bus_if.if_rvalid     = r_if_rvalid;
   assign bus_if.if_rdata      = r_if_rdata;
   assign bus_if.mem_rvalid    = r_mem_rvalid;
   assign bus_if.mem_rdata     = r_mem_rdata;
   assign bus_if.bus_timeout   = r_timeout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_owner      <= OWNER_IF;
         r_drop       <= 1'b0;
         r_cnt        <= '0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_wstrb      <= '0;
         r_if_rvalid  <= 1'b0;
         r_if_rdata   <= '0;
         r_mem_rvalid <= 1'b0;
         r_mem_rdata  <= '0;
         r_timeout    <= 1'b0;
      end else begin
         r_if_rvalid  <= 1'b0;
         r_mem_rvalid <= 1'b0;
         r_timeout    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_drop <= 1'b0;
               if (w_mem_hs) begin
                  r_owner <= OWNER_MEM;
                  r_we    <= bus_if.mem_we;
                  r_addr  <= bus_if.mem_addr;
                  r_wdata <= bus_if.mem_wdata;
                  r_wstrb <= bus_if.mem_wstrb;
                  r_state <= ST_REQ;
               end else if (w_if_hs) begin
                  r_owner <= OWNER_IF;
                  r_we    <= 1'b0;
                  r_addr  <= bus_if.if_addr;
                  r_wdata <= '0;
                  r_wstrb <= '0;
                  r_state <= ST_REQ;
               end
            end
            ST_REQ: begin
               r_drop <= w_drop;
               if (bus_if.bus_req_ready) begin
                  r_cnt   <= '0;
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               r_drop <= w_drop;
               r_cnt  <= r_cnt + CNT_W'(1);
               // A response wins over a simultaneous timeout
               if (bus_if.bus_resp_valid || w_abort) begin
                  r_state   <= ST_IDLE;
                  r_drop    <= 1'b0;
                  r_timeout <= ~bus_if.bus_resp_valid;
                  if (r_owner == OWNER_MEM) begin
                     r_mem_rvalid <= 1'b1;
                     r_mem_rdata  <= bus_if.bus_resp_valid ? bus_if.bus_resp_data : '0;
                  end else if (!w_drop) begin
                     r_if_rvalid <= 1'b1;
                     r_if_rdata  <= bus_if.bus_resp_valid ? bus_if.bus_resp_data : '0;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter (TIMEOUT_CYC = 4).
module tb_mem_bus_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   typedef struct {
      bit          is_mem;
      logic [63:0] data;
      bit          tmo;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   mem_bus_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bif ();

   mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYC(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bif.slave)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic push(input bit is_mem, input logic [63:0] data, input bit tmo);
      exp_t e;
      e.is_mem = is_mem;
      e.data   = data;
      e.tmo    = tmo;
      sb.push_back(e);
   endtask

   task automatic clear_inputs();
      bif.if_valid       = 1'b0;
      bif.if_addr        = '0;
      bif.if_flush       = 1'b0;
      bif.mem_valid      = 1'b0;
      bif.mem_we         = 1'b0;
      bif.mem_addr       = '0;
      bif.mem_wdata      = '0;
      bif.mem_wstrb      = '0;
      bif.bus_req_ready  = 1'b0;
      bif.bus_resp_valid = 1'b0;
      bif.bus_resp_data  = '0;
   endtask

   // From the drive phase of a REQ cycle: accept now, respond on the next cycle
   task automatic serve(input bit is_mem, input logic [63:0] data, input bit expect_rsp);
      bif.bus_req_ready = 1'b1;
      cyc();
      bif.bus_req_ready  = 1'b0;
      bif.bus_resp_valid = 1'b1;
      bif.bus_resp_data  = data;
      if (expect_rsp) push(is_mem, data, 1'b0);
      cyc();
      bif.bus_resp_valid = 1'b0;
   endtask

   // Response monitor: every pulse must match the oldest expected entry
   always @(negedge clk) begin
      if (!rst && (bif.if_rvalid || bif.mem_rvalid || bif.bus_timeout)) begin
         if (sb.size() == 0) begin
            check("sb_unexpected", 64'({bif.if_rvalid, bif.mem_rvalid, bif.bus_timeout}), 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_if_rvalid",  64'(bif.if_rvalid),  64'(!e.is_mem));
            check("sb_mem_rvalid", 64'(bif.mem_rvalid), 64'(e.is_mem));
            check("sb_timeout",    64'(bif.bus_timeout), 64'(e.tmo));
            check("sb_rdata", e.is_mem ? bif.mem_rdata : bif.if_rdata, e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      clear_inputs();
      repeat (3) cyc();
      mid();
      check("rst_bus_req_valid", 64'(bif.bus_req_valid), 64'd0);
      check("rst_if_rvalid",     64'(bif.if_rvalid),     64'd0);
      check("rst_mem_rvalid",    64'(bif.mem_rvalid),    64'd0);
      check("rst_bus_addr",      bif.bus_addr,           64'd0);
      check("rst_timeout",       64'(bif.bus_timeout),   64'd0);
      cyc();
      rst = 1'b0;
      cyc();

      // IF read, minimum latency
      bif.if_valid = 1'b1;
      bif.if_addr  = 64'h8000_0000;
      mid();
      check("t1_if_ready",  64'(bif.if_ready),  64'd1);
      check("t1_mem_ready", 64'(bif.mem_ready), 64'd0);
      cyc();
      bif.if_valid = 1'b0;
      mid();
      check("t1_req_valid", 64'(bif.bus_req_valid), 64'd1);
      check("t1_bus_addr",  bif.bus_addr,           64'h8000_0000);
      check("t1_bus_we",    64'(bif.bus_we),        64'd0);
      serve(1'b0, 64'h1122334455667788, 1'b1);
      mid();
      check("t1_if_rvalid_c3", 64'(bif.if_rvalid), 64'd1);

      // MEM store beats simultaneous IF; IF granted in the rvalid cycle
      cyc();
      bif.mem_valid = 1'b1;
      bif.mem_we    = 1'b1;
      bif.mem_addr  = 64'h100;
      bif.mem_wdata = 64'hAB;
      bif.mem_wstrb = 8'h01;
      bif.if_valid  = 1'b1;
      bif.if_addr   = 64'h200;
      mid();
      check("t2_mem_ready", 64'(bif.mem_ready), 64'd1);
      check("t2_if_ready",  64'(bif.if_ready),  64'd0);
      cyc();
      bif.mem_valid = 1'b0;
      mid();
      check("t2_bus_we",    64'(bif.bus_we),    64'd1);
      check("t2_bus_wstrb", 64'(bif.bus_wstrb), 64'h01);
      check("t2_bus_addr",  bif.bus_addr,       64'h100);
      check("t2_bus_wdata", bif.bus_wdata,      64'hAB);
      check("t2_if_ready_req", 64'(bif.if_ready), 64'd0);
      serve(1'b1, 64'h5A5A, 1'b1);
      mid();
      check("t2_mem_rvalid",   64'(bif.mem_rvalid), 64'd1);
      check("t2_if_ready_idle", 64'(bif.if_ready),  64'd1);
      cyc();
      bif.if_valid = 1'b0;
      mid();
      check("t2_if_bus_addr",  bif.bus_addr,       64'h200);
      check("t2_if_bus_wstrb", 64'(bif.bus_wstrb), 64'd0);
      check("t2_if_bus_we",    64'(bif.bus_we),    64'd0);
      serve(1'b0, 64'hCAFE_0002, 1'b1);
      mid();

      // bus_req_ready held low: request stable, no second grant
      cyc();
      bif.mem_valid = 1'b1;
      bif.mem_we    = 1'b0;
      bif.mem_addr  = 64'h300;
      bif.mem_wstrb = '0;
      cyc();
      bif.if_valid = 1'b1;
      bif.if_addr  = 64'h310;
      for (int i = 0; i < 5; i++) begin
         mid();
         check("t3_req_valid", 64'(bif.bus_req_valid), 64'd1);
         check("t3_bus_addr",  bif.bus_addr,           64'h300);
         check("t3_mem_ready", 64'(bif.mem_ready),     64'd0);
         check("t3_if_ready",  64'(bif.if_ready),      64'd0);
         cyc();
      end
      bif.mem_valid = 1'b0;
      bif.if_valid  = 1'b0;
      serve(1'b1, 64'h3333, 1'b1);
      mid();

      // IF flush during WAIT drops the response
      cyc();
      bif.if_valid = 1'b1;
      bif.if_addr  = 64'h400;
      cyc();
      bif.if_valid      = 1'b0;
      bif.bus_req_ready = 1'b1;
      cyc();
      bif.bus_req_ready = 1'b0;
      bif.if_flush      = 1'b1;
      cyc();
      bif.if_flush       = 1'b0;
      bif.bus_resp_valid = 1'b1;
      bif.bus_resp_data  = 64'hDEAD;
      cyc();
      bif.bus_resp_valid = 1'b0;
      bif.if_valid       = 1'b1;
      bif.if_addr        = 64'h500;
      mid();
      check("t4_if_rvalid_dropped", 64'(bif.if_rvalid), 64'd0);
      check("t4_if_ready_idle",     64'(bif.if_ready),  64'd1);
      cyc();
      bif.if_valid = 1'b0;
      mid();
      check("t4_next_addr", bif.bus_addr, 64'h500);
      serve(1'b0, 64'h5555_AAAA, 1'b1);
      mid();
      check("t4_next_rvalid", 64'(bif.if_rvalid), 64'd1);

      // MEM load timeout, late response ignored
      cyc();
      bif.mem_valid = 1'b1;
      bif.mem_addr  = 64'h600;
      cyc();
      bif.mem_valid     = 1'b0;
      bif.bus_req_ready = 1'b1;
      cyc();
      bif.bus_req_ready = 1'b0;
      push(1'b1, 64'd0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         mid();
         check("t5_no_early_tmo", 64'(bif.bus_timeout), 64'd0);
         cyc();
      end
      mid();
      check("t5_timeout",    64'(bif.bus_timeout), 64'd1);
      check("t5_mem_rvalid", 64'(bif.mem_rvalid),  64'd1);
      check("t5_mem_rdata",  bif.mem_rdata,        64'd0);
      cyc();
      bif.bus_resp_valid = 1'b1;
      bif.bus_resp_data  = 64'hBEEF;
      cyc();
      bif.bus_resp_valid = 1'b0;
      mid();
      check("t5_late_ignored", 64'(bif.mem_rvalid),    64'd0);
      check("t5_idle",         64'(bif.bus_req_valid), 64'd0);

      // Reset in WAIT clears everything immediately
      cyc();
      bif.if_valid = 1'b1;
      bif.if_addr  = 64'h700;
      cyc();
      bif.if_valid      = 1'b0;
      bif.bus_req_ready = 1'b1;
      cyc();
      bif.bus_req_ready = 1'b0;
      rst = 1'b1;
      #1;
      check("t6_req_valid", 64'(bif.bus_req_valid), 64'd0);
      check("t6_bus_addr",  bif.bus_addr,           64'd0);
      check("t6_if_rdata",  bif.if_rdata,           64'd0);
      check("t6_if_rvalid", 64'(bif.if_rvalid),     64'd0);
      cyc();
      bif.bus_resp_valid = 1'b1;
      bif.bus_resp_data  = 64'h9999;
      cyc();
      bif.bus_resp_valid = 1'b0;
      rst = 1'b0;
      cyc();
      bif.mem_valid = 1'b1;
      bif.mem_we    = 1'b1;
      bif.mem_addr  = 64'h800;
      bif.mem_wdata = 64'h1234;
      bif.mem_wstrb = 8'hF0;
      mid();
      check("t6_mem_ready", 64'(bif.mem_ready), 64'd1);
      cyc();
      bif.mem_valid = 1'b0;
      mid();
      check("t6_req_valid_c1", 64'(bif.bus_req_valid), 64'd1);
      check("t6_bus_wstrb",    64'(bif.bus_wstrb),     64'hF0);
      serve(1'b1, 64'h77, 1'b1);
      mid();
      check("t6_mem_rvalid_c3", 64'(bif.mem_rvalid), 64'd1);
      cyc();
      mid();

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
